unidade_controle_rodadas: RTL
=============================

UNIDADE_CONTROLE_RODADAS -- requirements
Module: unidade_controle_rodadas

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CICLOS, default 5000, the number of clock cycles allowed in espera before timeout (legal range 2..2^20).
REQ-002 The block SHALL have input clock, 1 bit: system clock, rising edge.
REQ-003 The block SHALL have input reset, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have input iniciar, 1 bit: start or restart game.
REQ-005 The block SHALL have input jogada, 1 bit: player move present.
REQ-006 The block SHALL have input igual, 1 bit: registered move equals memory.
REQ-007 The block SHALL have input fimE, 1 bit: move address at last position of current round.
REQ-008 The block SHALL have input fimR, 1 bit: round counter at last round.
REQ-009 The block SHALL have input modo, 1 bit: 0 = single full-sequence round, 1 = progressive rounds.
REQ-010 The block SHALL have outputs zeraE, contaE, zeraR, contaR, registraR and limpaR, 1 bit each: datapath controls for the move counter, round counter and move register.
REQ-011 The block SHALL have outputs acertou, errou, timeout and pronto, 1 bit each: game result flags.
REQ-012 The block SHALL have output db_estado, 4 bits: state code.
REQ-013 The block SHALL have output db_modo, 1 bit: latched mode.

Function
REQ-014 The FSM SHALL be Moore with these states and codes: inicial=0, preparacao=1, inicio_rodada=2, espera=3, registra=4, compara=5, proxima_jogada=6, proxima_rodada=7, final_acerto=8, final_erro=9, final_timeout=10.
REQ-015 inicial SHALL go to preparacao when iniciar=1, else hold.
REQ-016 preparacao SHALL go to inicio_rodada unconditionally, and SHALL latch modo into db_modo on that edge.
REQ-017 inicio_rodada SHALL go to espera unconditionally.
REQ-018 espera SHALL go to registra if jogada=1; otherwise to final_timeout if the timeout count equals TIMEOUT_CICLOS-1; otherwise hold; jogada SHALL win on a simultaneous event.
REQ-019 registra SHALL go to compara unconditionally.
REQ-020 compara SHALL go to final_erro if igual=0.
REQ-021 compara SHALL go to proxima_jogada if igual=1 and fimE=0.
REQ-022 compara SHALL go to final_acerto if igual=1, fimE=1, and either db_modo=0 or fimR=1.
REQ-023 compara SHALL go to proxima_rodada if igual=1, fimE=1, db_modo=1 and fimR=0.
REQ-024 proxima_jogada SHALL go to espera, and proxima_rodada SHALL go to inicio_rodada.
REQ-025 Each final state SHALL go to preparacao when iniciar=1, else hold.
REQ-026 Unused state codes SHALL go to inicial.
REQ-027 Outputs SHALL be decoded as follows: zeraE in inicial, preparacao and inicio_rodada; zeraR in inicial and preparacao; limpaR in preparacao; registraR in registra; contaE in proxima_jogada; contaR in proxima_rodada.
REQ-028 pronto SHALL be active in all three final states; acertou only in final_acerto, errou only in final_erro, timeout only in final_timeout.
REQ-029 db_estado SHALL equal the state code; an illegal code SHALL display 4'hF.
REQ-030 The timeout counter SHALL be $clog2(TIMEOUT_CICLOS) bits wide.
REQ-031 The timeout counter SHALL be held at 0 in every state except espera, and SHALL increment by 1 per cycle in espera without wrapping.
REQ-032 The timeout count SHALL restart at 0 on every re-entry to espera.
REQ-033 A change of modo after preparacao SHALL have no effect until the next preparacao.

Reset
REQ-034 On reset=1, asynchronously: state SHALL be inicial, the timeout counter 0, and db_modo 0.
REQ-035 Under reset, zeraE=zeraR=1, all other control and result outputs SHALL be 0, and db_estado SHALL be 0.
REQ-036 Reset asserted mid-game SHALL abort immediately, with no pending pulse emitted after release.

Structure
REQ-037 State codes and the illegal-code display value SHALL live in the shared package unidade_controle_rodadas_pkg.
REQ-038 The timeout counter SHALL be the sub-module contador_timeout, parametrised by modulus, with clear, enable and terminal-count outputs.

Verification (bench uses TIMEOUT_CICLOS=8)
REQ-039 Test modo=0 perfect game: iniciar, then 4 moves with igual=1 and fimE on the 4th -> contaE pulses 3 times, state ends at 8, acertou=pronto=1.
REQ-040 Test modo=1 progressive game: 3 rounds, with fimE at the end of each round and fimR in round 3 -> contaR pulses 2 times, zeraE pulses on each inicio_rodada, final state is 8.
REQ-041 Test wrong move: igual=0 at compara -> state 9, errou=1; then iniciar -> preparacao with limpaR pulse.
REQ-042 Test timeout: no jogada for 8 cycles in espera -> state 10, timeout=1; jogada on the 8th cycle -> registra instead.
REQ-043 Test reset during compara: reset asserted -> state 0 immediately, and no contaE or registraR pulse after release.
REQ-044 Test mode change: toggle modo during espera -> db_modo unchanged and progression unchanged.

Source files
------------

// File: rtl/unidade_controle_rodadas_pkg.sv
// Shared definitions for the round controller of the sequence-memory game.
// Holds the state encoding, the display value for an illegal state and the
// Moore output decode so the top level and any bench/debug logic agree.
package unidade_controle_rodadas_pkg;

   typedef enum logic [3:0] {
      INICIAL        = 4'd0,
      PREPARACAO     = 4'd1,
      INICIO_RODADA  = 4'd2,
      ESPERA         = 4'd3,
      REGISTRA       = 4'd4,
      COMPARA        = 4'd5,
      PROXIMA_JOGADA = 4'd6,
      PROXIMA_RODADA = 4'd7,
      FINAL_ACERTO   = 4'd8,
      FINAL_ERRO     = 4'd9,
      FINAL_TIMEOUT  = 4'd10
   } estado_t;

   localparam logic [3:0] ESTADO_INVALIDO = 4'hF;

   typedef struct packed {
      logic       zeraE;
      logic       contaE;
      logic       zeraR;
      logic       contaR;
      logic       registraR;
      logic       limpaR;
      logic       acertou;
      logic       errou;
      logic       timeout;
      logic       pronto;
      logic [3:0] estado;
   } saidas_t;

   // Moore decode of a state code into datapath controls and result flags.
   function automatic saidas_t decodifica(input logic [3:0] e);
      saidas_t s;
      s        = '0;
      s.estado = e;
      case (e)
         INICIAL:        begin s.zeraE = 1'b1; s.zeraR = 1'b1; end
         PREPARACAO:     begin s.zeraE = 1'b1; s.zeraR = 1'b1; s.limpaR = 1'b1; end
         INICIO_RODADA:  s.zeraE     = 1'b1;
         ESPERA:         ;
         REGISTRA:       s.registraR = 1'b1;
         COMPARA:        ;
         PROXIMA_JOGADA: s.contaE    = 1'b1;
         PROXIMA_RODADA: s.contaR    = 1'b1;
         FINAL_ACERTO:   begin s.acertou = 1'b1; s.pronto = 1'b1; end
         FINAL_ERRO:     begin s.errou   = 1'b1; s.pronto = 1'b1; end
         FINAL_TIMEOUT:  begin s.timeout = 1'b1; s.pronto = 1'b1; end
         default:        s.estado = ESTADO_INVALIDO;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/unidade_controle_rodadas_if.sv
// Signal bundle between the round controller and its datapath.
//   slave  : the controller (game status in, controls/flags/debug out)
//   master : the datapath or a bench driving it
interface unidade_controle_rodadas_if;
   // status from datapath / player
   logic       iniciar;
   logic       jogada;
   logic       igual;
   logic       fimE;
   logic       fimR;
   logic       modo;
   // datapath controls
   logic       zeraE;
   logic       contaE;
   logic       zeraR;
   logic       contaR;
   logic       registraR;
   logic       limpaR;
   // results and debug
   logic       acertou;
   logic       errou;
   logic       timeout;
   logic       pronto;
   logic [3:0] db_estado;
   logic       db_modo;

   modport slave (
      input  iniciar, jogada, igual, fimE, fimR, modo,
      output zeraE, contaE, zeraR, contaR, registraR, limpaR,
             acertou, errou, timeout, pronto, db_estado, db_modo
   );

   modport master (
      output iniciar, jogada, igual, fimE, fimR, modo,
      input  zeraE, contaE, zeraR, contaR, registraR, limpaR,
             acertou, errou, timeout, pronto, db_estado, db_modo
   );
endinterface

// File: rtl/contador_timeout.sv
// Saturating up-counter used to time the player's wait for a move.
//   clock, reset : rising-edge clock, async active-high reset
//   limpa_i      : synchronous clear (wins over conta_i)
//   conta_i      : count enable; stops at MODULO-1, never wraps
//   fim_o        : count has reached MODULO-1
module contador_timeout #(
   parameter int MODULO = 5000
) (
   input  logic clock,
   input  logic reset,
   input  logic limpa_i,
   input  logic conta_i,
   output logic fim_o
);
   localparam int W = $clog2(MODULO);
   localparam logic [W-1:0] ULTIMO = W'(MODULO - 1);

   logic [W-1:0] valor_q, valor_d;

   always_comb begin
      valor_d = valor_q;
      if (limpa_i)                          valor_d = '0;
      else if (conta_i && valor_q != ULTIMO) valor_d = valor_q + 1'b1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) valor_q <= '0;
      else       valor_q <= valor_d;
   end

   assign fim_o = (valor_q == ULTIMO);
endmodule

// File: rtl/unidade_controle_rodadas.sv
// Round controller FSM for the sequence-memory game.
//   clock, reset     : rising-edge clock, async active-high reset
//   bus (slave)      : iniciar/jogada/igual/fimE/fimR/modo in;
//                      zeraE/contaE/zeraR/contaR/registraR/limpaR controls,
//                      acertou/errou/timeout/pronto results,
//                      db_estado (state code) and db_modo (latched mode) out
// Outputs are registered from the next state, so they behave exactly like a
// Moore decode of the current state but leave the block glitch-free.
module unidade_controle_rodadas
   import unidade_controle_rodadas_pkg::*;
#(
   parameter int TIMEOUT_CICLOS = 5000
) (
   input  logic                          clock,
   input  logic                          reset,
   unidade_controle_rodadas_if.slave     bus
);

   estado_t estado_q, estado_d;
   saidas_t saida_q;
   logic    modo_q;
   logic    fim_timeout;

   // Counter is cleared in every state but espera, so each entry restarts at 0.
   contador_timeout #(.MODULO(TIMEOUT_CICLOS)) u_timeout (
      .clock   (clock),
      .reset   (reset),
      .limpa_i (estado_q != ESPERA),
      .conta_i (estado_q == ESPERA),
      .fim_o   (fim_timeout)
   );

   always_comb begin
      estado_d = estado_q;
      case (estado_q)
         INICIAL:        if (bus.iniciar) estado_d = PREPARACAO;
         PREPARACAO:     estado_d = INICIO_RODADA;
         INICIO_RODADA:  estado_d = ESPERA;
         // a move arriving on the last allowed cycle still counts
         ESPERA:         if (bus.jogada)    estado_d = REGISTRA;
                         else if (fim_timeout) estado_d = FINAL_TIMEOUT;
         REGISTRA:       estado_d = COMPARA;
         COMPARA:        if (!bus.igual)           estado_d = FINAL_ERRO;
                         else if (!bus.fimE)       estado_d = PROXIMA_JOGADA;
                         else if (!modo_q || bus.fimR) estado_d = FINAL_ACERTO;
                         else                      estado_d = PROXIMA_RODADA;
         PROXIMA_JOGADA: estado_d = ESPERA;
         PROXIMA_RODADA: estado_d = INICIO_RODADA;
         FINAL_ACERTO,
         FINAL_ERRO,
         FINAL_TIMEOUT:  if (bus.iniciar) estado_d = PREPARACAO;
         default:        estado_d = INICIAL;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado_q <= INICIAL;
         saida_q  <= decodifica(INICIAL);
         modo_q   <= 1'b0;
      end else begin
         estado_q <= estado_d;
         saida_q  <= decodifica(estado_d);
         // mode is sampled only when leaving preparacao
         if (estado_q == PREPARACAO) modo_q <= bus.modo;
      end
   end

   assign bus.zeraE     = saida_q.zeraE;
   assign bus.contaE    = saida_q.contaE;
   assign bus.zeraR     = saida_q.zeraR;
   assign bus.contaR    = saida_q.contaR;
   assign bus.registraR = saida_q.registraR;
   assign bus.limpaR    = saida_q.limpaR;
   assign bus.acertou   = saida_q.acertou;
   assign bus.errou     = saida_q.errou;
   assign bus.timeout   = saida_q.timeout;
   assign bus.pronto    = saida_q.pronto;
   assign bus.db_estado = saida_q.estado;
   assign bus.db_modo   = modo_q;

endmodule
